// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and limits for the UART packet transmit arbiter.
package uart_tx_arbiter_pkg;

    localparam int unsigned N_PORTS_MIN            = 2;
    localparam int unsigned N_PORTS_MAX            = 8;
    localparam int unsigned N_PORTS_DEFAULT        = 2;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 4096;

    // One beat of a UART packet stream.
    typedef struct packed {
        logic       Valid;
        logic       SoP;
        logic       EoP;
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
    } UART_PACKET;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ARB_STATE;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search: the first requester after the pointer wins.
module uart_tx_arbiter_rr_picker #(
    parameter int unsigned N_PORTS = 2
) (
    input  logic [N_PORTS-1:0]         ipRequest,
    input  logic [$clog2(N_PORTS)-1:0] ipPointer,
    output logic [N_PORTS-1:0]         opWinner,
    output logic                       opAnyRequest
);

    int unsigned offset [N_PORTS];
    int unsigned bestOffset;

    // Distance of each port from pointer+1 (mod N); smallest requesting distance wins.
    always_comb begin
        bestOffset = N_PORTS;
        for (int unsigned j = 0; j < N_PORTS; j++) begin
            offset[j] = (j + N_PORTS - 1 - 32'(ipPointer)) % N_PORTS;
            if (ipRequest[j] && (offset[j] < bestOffset)) begin
                bestOffset = offset[j];
            end
        end
        opWinner = '0;
        for (int unsigned j = 0; j < N_PORTS; j++) begin
            opWinner[j] = ipRequest[j] && (offset[j] == bestOffset);
        end
    end

    assign opAnyRequest = |ipRequest;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the UART packet transmitter,
// with one registered output stage and a mid-packet stall watchdog.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_PORTS        = N_PORTS_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                     ipClk,
    input  logic                     ipnReset,
    input  UART_PACKET [N_PORTS-1:0] ipTxStreams,
    output logic       [N_PORTS-1:0] opTxReady,
    output UART_PACKET               opTxStream,
    input  logic                     ipTxReady,
    output logic       [N_PORTS-1:0] opGrant,
    output logic                     opTimeout
);

    localparam int unsigned PW  = $clog2(N_PORTS);
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

    if ((N_PORTS < N_PORTS_MIN) || (N_PORTS > N_PORTS_MAX)) begin : gPortRangeCheck
        $error("uart_tx_arbiter: N_PORTS out of range");
    end

    logic [1:0]         resetSync;
    logic               nReset;

    ARB_STATE           state;
    ARB_STATE           stateNext;
    logic [N_PORTS-1:0] grant;
    logic [N_PORTS-1:0] grantNext;
    logic [PW-1:0]      pointer;
    logic [PW-1:0]      pointerNext;
    logic [WDW-1:0]     wdCount;
    logic [WDW-1:0]     wdCountNext;
    logic               timeoutReg;
    logic               timeoutNext;

    UART_PACKET         outReg;
    UART_PACKET         outRegNext;
    UART_PACKET         ownerBeat;

    logic [N_PORTS-1:0] sopRequest;
    logic [N_PORTS-1:0] winner;
    logic [PW-1:0]      winnerIndex;
    logic               anyRequest;
    logic               ownerReady;
    logic               accept;
    logic               watchdogExpired;

    // Reset asserts asynchronously and releases on the second clock edge.
    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            resetSync <= '0;
        end else begin
            resetSync <= {resetSync[0], 1'b1};
        end
    end

    assign nReset = resetSync[1];

    // Only a beat carrying SoP may start a new grant.
    always_comb begin
        for (int unsigned j = 0; j < N_PORTS; j++) begin
            sopRequest[j] = ipTxStreams[j].Valid && ipTxStreams[j].SoP;
        end
    end

    uart_tx_arbiter_rr_picker #(
        .N_PORTS (N_PORTS)
    ) uPicker (
        .ipRequest    (sopRequest),
        .ipPointer    (pointer),
        .opWinner     (winner),
        .opAnyRequest (anyRequest)
    );

    // Encode the one-hot winner as the next pointer value.
    always_comb begin
        winnerIndex = '0;
        for (int unsigned j = 0; j < N_PORTS; j++) begin
            if (winner[j]) begin
                winnerIndex = PW'(j);
            end
        end
    end

    // Select the current owner's beat through the one-hot grant.
    always_comb begin
        ownerBeat = '0;
        for (int unsigned j = 0; j < N_PORTS; j++) begin
            if (grant[j]) begin
                ownerBeat = ipTxStreams[j];
            end
        end
    end

    assign ownerReady      = !outReg.Valid || ipTxReady;
    assign accept          = (state == BUSY) && ownerBeat.Valid && ownerReady;
    assign watchdogExpired = (state == BUSY) && !ownerBeat.Valid
                             && (wdCount == WDW'(TIMEOUT_CYCLES - 1));

    // Next-state, grant, pointer, watchdog and owner ready.
    always_comb begin
        stateNext   = state;
        grantNext   = grant;
        pointerNext = pointer;
        wdCountNext = wdCount;
        timeoutNext = 1'b0;
        opTxReady   = '0;
        unique case (state)
            IDLE: begin
                wdCountNext = '0;
                if (anyRequest) begin
                    stateNext   = BUSY;
                    grantNext   = winner;
                    pointerNext = winnerIndex;
                end
            end
            BUSY: begin
                opTxReady = grant & {N_PORTS{ownerReady}};
                if (accept) begin
                    wdCountNext = '0;
                    if (ownerBeat.EoP) begin
                        stateNext = IDLE;
                        grantNext = '0;
                    end
                end else if (!ownerBeat.Valid) begin
                    if (watchdogExpired) begin
                        stateNext   = IDLE;
                        grantNext   = '0;
                        timeoutNext = 1'b1;
                        wdCountNext = '0;
                    end else begin
                        wdCountNext = wdCount + WDW'(1);
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                grantNext = '0;
            end
        endcase
    end

    // FSM, grant, pointer and watchdog registers.
    always_ff @(posedge ipClk or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            grant      <= '0;
            pointer    <= PW'(N_PORTS - 1);
            wdCount    <= '0;
            timeoutReg <= 1'b0;
        end else begin
            state      <= stateNext;
            grant      <= grantNext;
            pointer    <= pointerNext;
            wdCount    <= wdCountNext;
            timeoutReg <= timeoutNext;
        end
    end

    // Output stage: load on accept, drop Valid once drained, hold while stalled.
    always_comb begin
        outRegNext = outReg;
        if (accept) begin
            outRegNext = ownerBeat;
        end else if (ipTxReady) begin
            outRegNext.Valid = 1'b0;
        end
    end

    // Output stage register.
    always_ff @(posedge ipClk or negedge nReset) begin
        if (!nReset) begin
            outReg <= '0;
        end else begin
            outReg <= outRegNext;
        end
    end

    assign opTxStream = outReg;
    assign opGrant    = grant;
    assign opTimeout  = timeoutReg;

endmodule
